// File: rtl/elevator_pkg.sv
// Shared types, sizes and small helpers for the four-floor elevator controller.
package elevator_pkg;
  localparam int NFLOORS = 4;
  localparam int FLOOR_W = 2;
  localparam int CABIN_W = 4 * NFLOORS;

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;
  typedef enum logic [1:0] {DIR_IDLE = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10} dir_t;

  function automatic logic [NFLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return NFLOORS'(1) << f;
  endfunction

  // Lights the 4-bit column of the cabin matrix belonging to floor f.
  function automatic logic [CABIN_W-1:0] cabin_pattern(input logic [FLOOR_W-1:0] f);
    return CABIN_W'(4'hF) << {f, 2'b00};
  endfunction
endpackage

// File: rtl/elevator_if.sv
// Call inputs, timing strobe and status outputs of the elevator controller.
interface elevator_if;
  import elevator_pkg::*;

  logic               tick;
  logic [NFLOORS-1:0] call_req;
  logic [NFLOORS-1:0] pending;
  logic [FLOOR_W-1:0] floor;
  logic [1:0]         dir;
  logic               moving;
  logic               door_open;
  logic [CABIN_W-1:0] cabin;

  modport master (output tick, call_req,
                  input  pending, floor, dir, moving, door_open, cabin);
  modport slave  (input  tick, call_req,
                  output pending, floor, dir, moving, door_open, cabin);
endinterface

// File: rtl/elevator_timer.sv
// Tick counter: done pulses combinationally on the LIMIT-th enabled tick, then wraps to 0.
module elevator_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  logic [3:0] count_reg;

  assign done = enable && (count_reg == 4'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (done) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 4'd1;
    end
  end
endmodule

// File: rtl/elevator_controller.sv
// Four-floor elevator FSM (IDLE/MOVE/DOOR) with latched calls and tick-paced travel/door timing.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  elevator_if.slave  bus
);
  state_t             state_reg;
  dir_t               dir_reg;
  dir_t               start_dir;
  logic [FLOOR_W-1:0] floor_reg;
  logic [FLOOR_W-1:0] floor_step;
  logic [NFLOORS-1:0] pending_reg;
  logic [NFLOORS-1:0] req_all;
  logic [NFLOORS-1:0] above;
  logic [NFLOORS-1:0] below;
  logic [CABIN_W-1:0] cabin_reg;
  logic               moving_reg;
  logic               door_reg;
  logic               travel_done;
  logic               door_done;

  // Decisions see this cycle's calls too, so a call at the current floor opens the door in one clk.
  assign req_all = pending_reg | bus.call_req;

  for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_side
    assign above[gi] = req_all[gi] && (gi > int'(floor_reg));
    assign below[gi] = req_all[gi] && (gi < int'(floor_reg));
  end

  assign floor_step = (dir_reg == DIR_DOWN) ? floor_reg - 2'd1 : floor_reg + 2'd1;

  always_comb begin
    start_dir = DIR_UP;
    if (dir_reg == DIR_UP)        start_dir = (|above) ? DIR_UP : DIR_DOWN;
    else if (dir_reg == DIR_DOWN) start_dir = (|below) ? DIR_DOWN : DIR_UP;
    else                          start_dir = (|above) ? DIR_UP : DIR_DOWN;
  end

  // Timers are held clear outside their state, so a tick on the entry edge is not counted.
  elevator_timer #(.LIMIT(TRAVEL_TICKS)) u_travel (
    .clk(clk), .reset(reset), .clear(state_reg != ST_MOVE),
    .enable(bus.tick && state_reg == ST_MOVE), .done(travel_done)
  );

  elevator_timer #(.LIMIT(DOOR_TICKS)) u_door (
    .clk(clk), .reset(reset), .clear(state_reg != ST_DOOR),
    .enable(bus.tick && state_reg == ST_DOOR), .done(door_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      floor_reg   <= '0;
      dir_reg     <= DIR_IDLE;
      pending_reg <= '0;
      moving_reg  <= 1'b0;
      door_reg    <= 1'b0;
      cabin_reg   <= cabin_pattern('0);
    end else begin
      pending_reg <= req_all;
      case (state_reg)
        ST_IDLE: begin
          if (req_all[floor_reg]) begin
            state_reg   <= ST_DOOR;
            door_reg    <= 1'b1;
            pending_reg <= req_all & ~floor_bit(floor_reg);
          end else if (req_all == '0) begin
            dir_reg <= DIR_IDLE;
          end else begin
            state_reg  <= ST_MOVE;
            moving_reg <= 1'b1;
            dir_reg    <= start_dir;
          end
        end
        ST_MOVE: begin
          if (travel_done) begin
            floor_reg <= floor_step;
            cabin_reg <= cabin_pattern(floor_step);
            if (req_all[floor_step]) begin
              state_reg   <= ST_DOOR;
              moving_reg  <= 1'b0;
              door_reg    <= 1'b1;
              pending_reg <= req_all & ~floor_bit(floor_step);
            end
          end
        end
        ST_DOOR: begin
          pending_reg <= req_all & ~floor_bit(floor_reg);
          if (door_done) begin
            state_reg <= ST_IDLE;
            door_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // A target is always pending ahead while moving, so stepping past the end floors must never happen.
  no_wrap: assert property (@(posedge clk) disable iff (reset)
    !(travel_done && ((dir_reg == DIR_UP && floor_reg == 2'd3) ||
                      (dir_reg == DIR_DOWN && floor_reg == 2'd0))));

  assign bus.pending   = pending_reg;
  assign bus.floor     = floor_reg;
  assign bus.dir       = dir_reg;
  assign bus.moving    = moving_reg;
  assign bus.door_open = door_reg;
  assign bus.cabin     = cabin_reg;
endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: TRAVEL_TICKS=4, DOOR_TICKS=3, tick every 10 clk.
module tb_elevator_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  elevator_if bus ();

  elevator_controller #(.TRAVEL_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Nine quiet clocks, then one clock with tick high; returns just after the tick edge.
  task automatic ticks(input int n);
    repeat (n) begin
      cyc(9);
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.call_req = '0;
    bus.tick = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic call(input logic [3:0] v);
    bus.call_req = v;
    cyc(1);
    bus.call_req = '0;
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.call_req = '0;

    // Reset state, then full trip 0 -> 3
    do_reset();
    check("rst_floor", 16'(bus.floor), 16'd0);
    check("rst_dir", 16'(bus.dir), 16'd0);
    check("rst_pending", 16'(bus.pending), 16'd0);
    check("rst_moving", 16'(bus.moving), 16'd0);
    check("rst_door", 16'(bus.door_open), 16'd0);
    check("rst_cabin", bus.cabin, 16'h000F);
    call(4'b1000);
    check("a_moving", 16'(bus.moving), 16'd1);
    check("a_dir", 16'(bus.dir), 16'd1);
    check("a_pending", 16'(bus.pending), 16'h8);
    ticks(3);
    check("a_floor_3t", 16'(bus.floor), 16'd0);
    ticks(1);
    check("a_floor1", 16'(bus.floor), 16'd1);
    check("a_cabin1", bus.cabin, 16'h00F0);
    ticks(4);
    check("a_floor2", 16'(bus.floor), 16'd2);
    ticks(4);
    check("a_floor3", 16'(bus.floor), 16'd3);
    check("a_door3", 16'(bus.door_open), 16'd1);
    check("a_moving3", 16'(bus.moving), 16'd0);
    check("a_pending3", 16'(bus.pending), 16'h0);
    check("a_cabin3", bus.cabin, 16'hF000);
    ticks(2);
    check("a_door_2t", 16'(bus.door_open), 16'd1);
    ticks(1);
    check("a_door_closed", 16'(bus.door_open), 16'd0);
    check("a_dir_kept", 16'(bus.dir), 16'd1);
    cyc(1);
    check("a_dir_idle", 16'(bus.dir), 16'd0);
    $display("scenario A: trip 0->3 done at %0t", $time);

    // Call for current floor opens the door one clk later
    do_reset();
    call(4'b0001);
    check("b_door", 16'(bus.door_open), 16'd1);
    check("b_pending", 16'(bus.pending), 16'h0);
    check("b_moving", 16'(bus.moving), 16'd0);
    ticks(3);
    check("b_door_closed", 16'(bus.door_open), 16'd0);
    $display("scenario B: same-floor call done at %0t", $time);

    // Intermediate stop at floor 1, calls for floor 1 held during DOOR
    call(4'b1000);
    ticks(2);
    call(4'b0010);
    check("c_pending_both", 16'(bus.pending), 16'hA);
    ticks(2);
    check("c_floor1", 16'(bus.floor), 16'd1);
    check("c_door1", 16'(bus.door_open), 16'd1);
    check("c_pending_after", 16'(bus.pending), 16'h8);
    bus.call_req = 4'b0010;
    cyc(1);
    check("c_held_pending", 16'(bus.pending), 16'h8);
    ticks(2);
    check("c_held_door", 16'(bus.door_open), 16'd1);
    check("c_held_pending2", 16'(bus.pending), 16'h8);
    ticks(1);
    bus.call_req = '0;
    check("c_door_closed", 16'(bus.door_open), 16'd0);
    check("c_pending_close", 16'(bus.pending), 16'h8);
    cyc(1);
    check("c_resume_moving", 16'(bus.moving), 16'd1);
    check("c_resume_dir", 16'(bus.dir), 16'd1);
    ticks(8);
    check("c_floor3", 16'(bus.floor), 16'd3);
    check("c_door3", 16'(bus.door_open), 16'd1);
    ticks(3);
    $display("scenario C: intermediate stop done at %0t", $time);

    // Idle at floor 2 with dir up: 1001 serves 3 first, then reverses to 0
    do_reset();
    call(4'b0100);
    ticks(8);
    check("d_floor2", 16'(bus.floor), 16'd2);
    check("d_door2", 16'(bus.door_open), 16'd1);
    ticks(3);
    check("d_idle_dir", 16'(bus.dir), 16'd1);
    call(4'b1001);
    check("d_dir_up", 16'(bus.dir), 16'd1);
    check("d_pending", 16'(bus.pending), 16'h9);
    ticks(4);
    check("d_floor3", 16'(bus.floor), 16'd3);
    check("d_pending3", 16'(bus.pending), 16'h1);
    ticks(3);
    cyc(1);
    check("d_dir_down", 16'(bus.dir), 16'd2);
    check("d_moving_down", 16'(bus.moving), 16'd1);
    ticks(4);
    check("d_floor2_down", 16'(bus.floor), 16'd2);
    ticks(8);
    check("d_floor0", 16'(bus.floor), 16'd0);
    check("d_door0", 16'(bus.door_open), 16'd1);
    check("d_pending0", 16'(bus.pending), 16'h0);
    check("d_cabin0", bus.cabin, 16'h000F);
    $display("scenario D: up then reverse done at %0t", $time);

    // Entry-edge tick ignored, then reset mid-MOVE at floor 2
    do_reset();
    bus.call_req = 4'b1000;
    bus.tick = 1'b1;
    cyc(1);
    bus.call_req = '0;
    bus.tick = 1'b0;
    check("e_moving", 16'(bus.moving), 16'd1);
    ticks(3);
    check("e_entry_tick_ignored", 16'(bus.floor), 16'd0);
    ticks(1);
    check("e_floor1", 16'(bus.floor), 16'd1);
    ticks(6);
    check("e_floor2", 16'(bus.floor), 16'd2);
    reset = 1'b1;
    cyc(1);
    check("e_rst_floor", 16'(bus.floor), 16'd0);
    check("e_rst_pending", 16'(bus.pending), 16'h0);
    check("e_rst_cabin", bus.cabin, 16'h000F);
    check("e_rst_moving", 16'(bus.moving), 16'd0);
    check("e_rst_dir", 16'(bus.dir), 16'd0);
    reset = 1'b0;
    ticks(4);
    check("e_stays_floor", 16'(bus.floor), 16'd0);
    check("e_stays_idle", 16'(bus.moving), 16'd0);
    $display("scenario E: reset mid-move done at %0t", $time);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 Parameter TRAVEL_TICKS, default 4: tick strobes needed to travel one floor; legal range 1..15.
REQ-002 Parameter DOOR_TICKS, default 3: tick strobes the door stays open; legal range 1..15.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle timing strobe (slow enable); all timers SHALL advance only on cycles with tick=1.
REQ-007 call_req  input  4  per-floor call buttons (floors 0..3), sampled every clk, pulse or level.
REQ-008 pending  output  4  latched outstanding calls.
REQ-009 floor  output  2  current cabin floor, binary.
REQ-010 dir  output  2  2'b00 idle, 2'b01 up, 2'b10 down; 2'b11 never driven.
REQ-011 moving  output  1  high in MOVE state.
REQ-012 door_open  output  1  high in DOOR state.
REQ-013 cabin  output  16  matrix pattern: bits [4*floor+3:4*floor]=4'hF, all other bits 0.

Function
REQ-014 States SHALL be IDLE, MOVE, DOOR; all outputs registered.
REQ-015 Each clk, pending SHALL be updated as pending | call_req, except that the bit for the current floor SHALL be cleared/not set while in DOOR.
REQ-016 "Ahead" means pending bits strictly above floor (dir up) or strictly below (dir down).
REQ-017 IDLE with pending[floor]=1: next edge SHALL enter DOOR, clear pending[floor], keep dir.
REQ-018 IDLE otherwise: if requests ahead in the current dir, continue that dir; else if requests in the opposite direction, reverse; with dir=00 and requests both above and below, choose up; enter MOVE on the next edge.
REQ-019 IDLE with pending=0 SHALL set dir=00 and remain in IDLE.
REQ-020 MOVE: the travel counter SHALL count tick strobes; on the TRAVEL_TICKS-th tick, floor SHALL change by +1 (up) or -1 (down) at that edge and the counter SHALL reset to 0.
REQ-021 On arrival: if pending[new floor]=1, enter DOOR and clear that bit; otherwise remain in MOVE in the same dir.
REQ-022 floor SHALL never wrap: up at floor 3 or down at floor 0 is forbidden by construction, and an assertion SHALL flag it.
REQ-023 DOOR: the door counter SHALL count ticks; on the DOOR_TICKS-th tick, the FSM SHALL return to IDLE with door_open=0 at that edge.
REQ-024 A call for another floor while in DOOR SHALL latch and be served only after DOOR exits.
REQ-025 A call for the current floor arriving in IDLE SHALL open the door with one-clk latency.
REQ-026 Simultaneous tick and state change: the tick SHALL count toward the new state's counter only from the cycle after entry; the entry-cycle tick SHALL be ignored.

Reset
REQ-027 reset SHALL force: state IDLE, floor 0, dir 00, pending 0, both counters 0, moving 0, door_open 0, cabin 16'h000F.
REQ-028 reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation with no further floor change and SHALL return the cabin to floor 0 immediately.

Structure
REQ-029 The shared package elevator_pkg SHALL hold: state enum, dir enum (DIR_IDLE, DIR_UP, DIR_DOWN), NFLOORS=4, floor width 2.
REQ-030 One sub-module, elevator_timer (tick counter with load/clear and a done pulse), SHALL be instantiated for both travel and door timing.
REQ-031 The block SHALL contain no latches; every combinational path SHALL have defaults.

Verification (TRAVEL_TICKS=4, DOOR_TICKS=3, tick every 10 clk)
REQ-032 Reset, then call_req=4'b1000 pulse -> MOVE up; floor steps 1,2,3 each after 4 ticks; DOOR at 3; IDLE after 3 ticks with pending=0 and dir=00.
REQ-033 At floor 0 idle, call_req=4'b0001 -> door_open=1 the next clk; pending stays 0.
REQ-034 Moving up from floor 0 to 3, call floor 1 injected before the floor-1 arrival -> stop at 1 (DOOR), then continue to 3.
REQ-035 Idle at floor 2 with dir=up, calls 4'b1001 together -> serve 3 first, then reverse and serve 0.
REQ-036 reset pulse while floor=2 in MOVE -> next clk floor=0, pending=0, cabin=16'h000F, IDLE.
REQ-037 Door open at floor 1 with call_req=4'b0010 held -> pending[1] stays 0; door closes after 3 ticks.
